// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : AXI4-Stream to UART transmitter, 8N1-style framing with a
//                configurable word width; bit period is 8*prescale clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    output logic                  txd,
    output logic                  busy,
    input  logic [15:0]           prescale
);

    // Start bit plus data bits; the stop bit is handled by the bit_cnt==1 leg.
    localparam logic [3:0] c_FRAME_CNT = 4'(DATA_WIDTH + 1);

    logic [18:0]           prescale_q, prescale_d;
    logic [3:0]            bit_cnt_q,  bit_cnt_d;
    logic [DATA_WIDTH-1:0] data_q,     data_d;
    logic                  txd_q,      txd_d;
    logic                  busy_q,     busy_d;
    logic                  tready_q,   tready_d;
    logic [18:0]           w_reload;

    // Sampled at every bit boundary, so a prescale change lands on the next bit.
    assign w_reload = ({3'b000, prescale} << 3) - 19'd1;

    always_comb begin
        prescale_d = prescale_q;
        bit_cnt_d  = bit_cnt_q;
        data_d     = data_q;
        txd_d      = txd_q;
        busy_d     = busy_q;
        tready_d   = tready_q;

        if (prescale_q != 19'd0) begin
            prescale_d = prescale_q - 19'd1;
            tready_d   = 1'b0;
        end else if (bit_cnt_q == 4'd0) begin
            busy_d   = 1'b0;
            tready_d = 1'b1;
            if (input_axis_tvalid && tready_q) begin
                data_d     = input_axis_tdata;
                txd_d      = 1'b0;
                prescale_d = w_reload;
                bit_cnt_d  = c_FRAME_CNT;
                busy_d     = 1'b1;
                tready_d   = 1'b0;
            end
        end else if (bit_cnt_q > 4'd1) begin
            {data_d, txd_d} = {1'b0, data_q};
            prescale_d      = w_reload;
            bit_cnt_d       = bit_cnt_q - 4'd1;
        end else begin
            txd_d      = 1'b1;
            prescale_d = w_reload;
            bit_cnt_d  = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescale_q <= 19'd0;
            bit_cnt_q  <= 4'd0;
            data_q     <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            tready_q   <= 1'b0;
        end else begin
            prescale_q <= prescale_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            tready_q   <= tready_d;
        end
    end

    assign input_axis_tready = tready_q;
    assign txd               = txd_q;
    assign busy              = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Self-checking bench for uart_tx against a bit-timeline model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int DW = 8;
    localparam int NB = DW + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] tdata = '0;
    logic          tvalid = 1'b0;
    logic [15:0]   prescale = 16'd1;
    wire           tready;
    wire           txd;
    wire           busy;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    uart_tx #(.DATA_WIDTH(DW)) dut (
        .clk               (clk),
        .rst               (rst),
        .input_axis_tdata  (tdata),
        .input_axis_tvalid (tvalid),
        .input_axis_tready (tready),
        .txd               (txd),
        .busy              (busy),
        .prescale          (prescale)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", checks, passed);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: the frame is a list of line levels; each bit lasts 8 * (prescale
    // seen on the edge that begins it). Optional prescale change at offset chg_at.
    task automatic send_frame(input logic [DW-1:0] data, input logic [DW-1:0] post,
                              input bit hold, input int chg_at, input logic [15:0] chg_p,
                              output int h_cyc);
        logic exp_bits[NB];
        int   lens[NB];
        int   starts[NB];
        int   t;
        int   budget;
        int   p0;
        bit   ok;
        int   bad_j;
        logic bad_txd, bad_busy, bad_tready;

        h_cyc  = 0;
        tdata  = data;
        tvalid = 1'b1;
        budget = 0;
        while (tready !== 1'b1 && budget < 2000) begin
            tick();
            budget++;
        end
        if (budget >= 2000) begin
            checks++;
            $display("FAIL handshake: tready stayed %b for %0d cycles, required 1", tready, budget);
            tvalid = 1'b0;
            return;
        end
        p0 = int'(prescale);
        tick();
        h_cyc = cyc;
        tdata = post;
        if (!hold) tvalid = 1'b0;

        t = 0;
        for (int b = 0; b < NB; b++) begin
            exp_bits[b] = (b == 0) ? 1'b0 : (b == NB - 1) ? 1'b1 : data[b-1];
            starts[b]   = t;
            lens[b]     = 8 * ((chg_at >= 0 && t > chg_at) ? int'(chg_p) : p0);
            t += lens[b];
        end

        for (int b = 0; b < NB; b++) begin
            ok = 1'b1;
            bad_j = 0; bad_txd = 1'b0; bad_busy = 1'b0; bad_tready = 1'b0;
            for (int c = 0; c < lens[b]; c++) begin
                if (ok && (txd !== exp_bits[b] || busy !== 1'b1 || tready !== 1'b0)) begin
                    ok = 1'b0;
                    bad_j = starts[b] + c;
                    bad_txd = txd; bad_busy = busy; bad_tready = tready;
                end
                if (starts[b] + c == chg_at) prescale = chg_p;
                tick();
            end
            checks++;
            if (ok) passed++;
            else $display("FAIL frame_bit%0d data=%h: txd=%b busy=%b tready=%b at offset %0d, required txd=%b busy=1 tready=0",
                          b, data, bad_txd, bad_busy, bad_tready, bad_j, exp_bits[b]);
        end

        checks++;
        if (busy === 1'b0 && tready === 1'b1 && txd === 1'b1) passed++;
        else $display("FAIL frame_end data=%h: busy=%b tready=%b txd=%b, required busy=0 tready=1 txd=1",
                      data, busy, tready, txd);
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        tvalid = 1'b0;
        repeat (3) tick();
        checks++;
        if (txd === 1'b1) passed++;
        else $display("FAIL reset_txd: got %b, required 1", txd);
        checks++;
        if (busy === 1'b0) passed++;
        else $display("FAIL reset_busy: got %b, required 0", busy);
        checks++;
        if (tready === 1'b0) passed++;
        else $display("FAIL reset_tready: got %b, required 0", tready);
        rst = 1'b0;
        tick();
        checks++;
        if (tready === 1'b1) passed++;
        else $display("FAIL reset_release_tready: got %b, required 1", tready);
    endtask

    task automatic test_frame_a5();
        int h;
        prescale = 16'd1;
        send_frame(8'hA5, 8'h00, 1'b0, -1, 16'd0, h);
    endtask

    task automatic test_back_to_back();
        int h1, h2;
        prescale = 16'd4;
        send_frame(8'h00, 8'h00, 1'b1, -1, 16'd0, h1);
        send_frame(8'hFF, 8'hFF, 1'b0, -1, 16'd0, h2);
        checks++;
        if (h2 - h1 == 321) passed++;
        else $display("FAIL back_to_back_period: got %0d clk, required 321", h2 - h1);
    endtask

    task automatic test_tdata_change();
        int h;
        prescale = 16'd1;
        send_frame(8'hC3, 8'h3C, 1'b0, -1, 16'd0, h);
    endtask

    task automatic test_reset_mid_frame();
        int   budget;
        int   h;
        logic [DW-1:0] d;
        d        = 8'hE5;
        prescale = 16'd2;
        tdata    = d;
        tvalid   = 1'b1;
        budget   = 0;
        while (tready !== 1'b1 && budget < 2000) begin
            tick();
            budget++;
        end
        tick();
        tvalid = 1'b0;
        repeat (16 * 5 + 7) tick();
        checks++;
        if (txd === d[4] && busy === 1'b1) passed++;
        else $display("FAIL pre_abort_bit4: txd=%b busy=%b, required txd=%b busy=1", txd, busy, d[4]);
        rst = 1'b1;
        tick();
        checks++;
        if (txd === 1'b1 && busy === 1'b0 && tready === 1'b0) passed++;
        else $display("FAIL abort_state: txd=%b busy=%b tready=%b, required 1 0 0", txd, busy, tready);
        rst    = 1'b0;
        tdata  = 8'h69;
        tvalid = 1'b1;
        tick();
        checks++;
        if (tready === 1'b1 && busy === 1'b0 && txd === 1'b1) passed++;
        else $display("FAIL tvalid_on_tready_rise: tready=%b busy=%b txd=%b, required 1 0 1", tready, busy, txd);
        send_frame(8'h69, 8'h00, 1'b0, -1, 16'd0, h);
    endtask

    task automatic test_prescale_change();
        int h;
        prescale = 16'd2;
        send_frame(8'h96, 8'h11, 1'b0, 16 * 3 + 5, 16'd3, h);
    endtask

    task automatic test_random();
        int h;
        for (int i = 0; i < 6; i++) begin
            prescale = 16'($urandom_range(1, 3));
            send_frame(8'($urandom), 8'($urandom), (i < 5) ? bit'($urandom_range(0, 1)) : 1'b0,
                       -1, 16'd0, h);
        end
        tvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_back_to_back();
        test_tdata_change();
        test_reset_mid_frame();
        test_prescale_change();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
